if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage LoongArch32 pipeline. It owns the PC, issues requests to the synchronous instruction SRAM and delivers `{inst, pc}` to the decode stage over the valid/allowin handshake. It also consumes the branch bus driven by decode, redirecting or freezing fetch on taken branches and on branch stalls.

## Interface
Parameters:
- `FS_TO_DS_BUS_WD`, 64: width of the fetch-to-decode bus, packed `{inst[31:0], pc[31:0]}`.
- `BR_BUS_WD`, 34: width of the branch bus, packed `{br_stall, br_taken, br_target[31:0]}`.
- `RESET_PC`, 32'h1c000000: address of the first fetch after reset.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `ds_allowin` in 1: decode can accept an instruction this cycle.
- `br_bus` in 34: branch bus from decode.
- `fs_to_ds_valid` out 1: the instruction on `fs_to_ds_bus` is valid.
- `fs_to_ds_bus` out 64: `{fs_inst, fs_pc}`.
- `inst_sram_en` out 1: read request strobe.
- `inst_sram_we` out 4: always 4'b0.
- `inst_sram_addr` out 32: request address.
- `inst_sram_wdata` out 32: always 32'b0.
- `inst_sram_rdata` in 32: read data, valid only in the cycle after the request.

## Operation
- **State:**
  - `fs_pc` (reset value `RESET_PC-4` = 32'h1bfffffc).
  - `fs_valid` (reset value 0).
  - `inst_buf[31:0]` and `inst_buf_valid` (reset value 0).
- **Redirect:** `redirect = br_taken & ds_allowin`. The branch in decode moves to execute at this edge.
- **Hold:** `hold = br_stall | (br_taken & ~ds_allowin)`. While hold is asserted, the branch target is unknown or not yet consumed.
- **Next PC:** `nextpc = redirect ? br_target : fs_pc + 4`. The addition wraps modulo 2^32.
- **Allowin:** `fs_allowin = ~fs_valid | ds_allowin`. The stage's ready_go is always 1.
- **Request:**
  - `inst_sram_en = ~reset & fs_allowin & ~hold`.
  - `inst_sram_addr = nextpc`.
  - On the request edge: `fs_pc <= nextpc` and `fs_valid <= 1`.
- **Drain with no new request:** if `fs_allowin` is high but no request is issued (hold active), set `fs_valid <= 0`. The previous instruction has either been handed over or cancelled.
- **Instruction source:** `fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata`.
- **Output valid:** `fs_to_ds_valid = fs_valid & ~br_taken & ~br_stall`. A sequential instruction behind a taken or stalled branch is never handed over. LoongArch has no delay slot.
- **Buffering:**
  - If `fs_valid & ~inst_buf_valid & ~ds_allowin`, capture `inst_sram_rdata` into `inst_buf` and set `inst_buf_valid <= 1`.
  - `inst_buf_valid` clears on any edge where `fs_valid` is replaced or cleared.
- **Cancel on redirect:** the current instruction (buffered or from SRAM) is discarded. The buffer clears and `fs_valid` is reloaded by the target request.

## Timing
- **Reset:**
  - While `reset` is high: `inst_sram_en=0`, `fs_to_ds_valid=0`, `inst_buf_valid=0`.
  - Reset assertion takes effect immediately (asynchronous), including mid-fetch. An outstanding SRAM response is ignored.
- **First request:** in the first cycle after reset deasserts, with addr = 32'h1c000000.
- **Fetch latency:**
  - Request in cycle t gives `fs_to_ds_valid` in cycle t+1, with `fs_pc` = the address requested in t.
  - Sustained throughput is 1 instruction/cycle while `ds_allowin=1` and no branch activity.
- **Backpressure:**
  - With `ds_allowin=0` for N cycles, `fs_to_ds_bus` stays constant and `inst_sram_en=0`.
  - The buffer is loaded at the end of the first stalled cycle.
- **Taken branch:**
  - Target request is issued in the same cycle as `br_taken & ds_allowin`.
  - The target instruction is valid one cycle later.
  - The taken-branch penalty is exactly one bubble.
- **`br_taken` with `ds_allowin=0`:** no request is issued, and fetch waits until `ds_allowin` rises.
- **`br_stall`:** no request and no hand-over, for as many cycles as it persists. Normal redirect rules resume afterwards.
- **`br_taken` and `br_stall` together:** stall takes priority (hold).
- **Wrap:** `fs_pc = 32'hfffffffc` yields a sequential request to 32'h00000000.

## Test plan
- **Reset release:** deassert reset with `ds_allowin=1` -> cycle 0: en=1, addr 0x1c000000; cycle 1: `fs_to_ds_valid=1`, pc 0x1c000000, then 0x1c000004, 0x1c000008 on consecutive cycles.
- **Backpressure:**
  - Stimulus: drop `ds_allowin` for 3 cycles while pc 0x1c000004 is valid, with the SRAM driving garbage after the response cycle.
  - Required: bus holds `{inst@0x1c000004, 0x1c000004}` unchanged and en=0 throughout.
  - On release: next request is 0x1c000008.
- **Taken branch:**
  - Stimulus: `br_taken=1`, target 0x1c000100, `ds_allowin=1`, while IF holds 0x1c000008.
  - Required: 0x1c000008 is never handed over; addr 0x1c000100 is requested the same cycle; valid next cycle.
- **Branch with decode stalled:** `br_taken=1`, `ds_allowin=0` for 2 cycles, then 1 -> en=0 for 2 cycles, then addr = target, and no instruction is handed over meanwhile.
- **Branch stall:** `br_stall=1` for 4 cycles -> en=0 and `fs_to_ds_valid=0` throughout; on release with `br_taken=1`, the target is fetched.
- **Asynchronous reset mid-fetch:** assert reset between edges with a valid buffered instruction -> outputs go to 0 immediately; after release the first addr is 0x1c000000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: LoongArch32 instruction fetch; owns the PC, drives the instruction SRAM
// and hands {inst, pc} to decode, buffering the SRAM word while decode is stalled.
module if_stage #(
   parameter int          FS_TO_DS_BUS_WD = 64,
   parameter int          BR_BUS_WD       = 34,
   parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_en,
   output logic [3:0]                 inst_sram_we,
   output logic [31:0]                inst_sram_addr,
   output logic [31:0]                inst_sram_wdata,
   input  logic [31:0]                inst_sram_rdata
);
   logic        br_stall, br_taken;
   logic [31:0] br_target;
   logic [31:0] fs_pc, nextpc, fs_inst, inst_buf;
   logic        fs_valid, inst_buf_valid;
   logic        redirect, hold, fs_allowin;
   assign {br_stall, br_taken, br_target} = br_bus;
   assign redirect        = br_taken & ds_allowin;
   assign hold            = br_stall | (br_taken & ~ds_allowin);
   assign nextpc          = redirect ? br_target : fs_pc + 32'd4;
   assign fs_allowin      = ~fs_valid | ds_allowin;
   assign inst_sram_en    = ~reset & fs_allowin & ~hold;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;
   assign fs_inst         = inst_buf_valid ? inst_buf : inst_sram_rdata;
   assign fs_to_ds_valid  = fs_valid & ~br_taken & ~br_stall;
   assign fs_to_ds_bus    = {fs_inst, fs_pc};
   // Whenever fs_allowin is high the current instruction leaves (handed over,
   // cancelled or drained), so the buffer is emptied on those edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fs_pc          <= RESET_PC - 32'd4;
         fs_valid       <= 1'b0;
         inst_buf       <= 32'b0;
         inst_buf_valid <= 1'b0;
      end else begin
         if (fs_allowin) fs_valid <= ~hold;
         if (inst_sram_en) fs_pc <= nextpc;
         if (fs_allowin) inst_buf_valid <= 1'b0;
         else if (~inst_buf_valid) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random fetch sequences against a transaction-level
// model in which the fetched word is a fixed function of its address.
module tb_if_stage;
   logic        clk = 0, reset = 1, ds_allowin = 0;
   logic [33:0] br_bus = '0;
   logic        fs_to_ds_valid, inst_sram_en;
   logic [63:0] fs_to_ds_bus;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] m_pc = 32'h1bfffffc;
   logic        m_valid = 0;

   if_stage dut (
      .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
      .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
   endfunction

   // Synchronous SRAM: the word is only valid the cycle after a request, garbage otherwise.
   always @(posedge clk) inst_sram_rdata <= (inst_sram_en && !reset) ? mem(inst_sram_addr) : $urandom;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rs, input logic st, input logic tk, input logic [31:0] tg, input logic al);
      logic fa, hold, en_e, v_e;
      logic [31:0] np;
      @(negedge clk);
      reset = rs; ds_allowin = al; br_bus = {st, tk, tg};
      #1;
      if (rs) begin m_valid = 0; m_pc = 32'h1bfffffc; end
      fa   = !m_valid || al;
      hold = st || (tk && !al);
      en_e = !rs && fa && !hold;
      np   = (tk && al) ? tg : m_pc + 32'd4;
      v_e  = m_valid && !tk && !st;
      chk("en", 64'(inst_sram_en), 64'(en_e));
      if (en_e) chk("addr", 64'(inst_sram_addr), 64'(np));
      chk("valid", 64'(fs_to_ds_valid), 64'(v_e));
      if (v_e) chk("bus", fs_to_ds_bus, {mem(m_pc), m_pc});
      chk("we_wdata", 64'({inst_sram_we, inst_sram_wdata}), 64'd0);
      if (!rs && fa) begin
         m_valid = !hold;
         if (!hold) m_pc = np;
      end
   endtask

   initial begin
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      // reset release and straight-line fetch
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // backpressure with pc 0x1c000004 valid
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      // taken branch while 0x1c000008 is held
      step(0, 0, 1, 32'h1c000100, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // taken branch with decode stalled
      step(0, 0, 1, 32'h1c000200, 0);
      step(0, 0, 1, 32'h1c000200, 0);
      step(0, 0, 1, 32'h1c000200, 1);
      step(0, 0, 0, 0, 1);
      // branch stall, including stall with taken, then redirect
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h1c000300, 1);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 32'h1c000300, 1);
      step(0, 0, 0, 0, 1);
      // PC wrap
      step(0, 0, 1, 32'hfffffff8, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      repeat (400) begin
         logic st, tk, al;
         st = ($urandom_range(7) == 0);
         tk = ($urandom_range(5) == 0);
         al = ($urandom_range(3) != 0);
         step(0, st, tk, $urandom & 32'hfffffffc, al);
      end
      // asynchronous reset mid-cycle with a buffered instruction
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("async_en", 64'(inst_sram_en), 64'd0);
      chk("async_valid", 64'(fs_to_ds_valid), 64'd0);
      chk("async_buf", 64'(dut.inst_buf_valid), 64'd0);
      m_valid = 0; m_pc = 32'h1bfffffc;
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
